// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: one memory port shared between LSQ loads and a
// committed-store FIFO, with store-to-load forwarding and store anti-starvation.
module dmem_port_arbiter #(
    parameter int SB_DEPTH   = 4,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [31:0] ld_pc,
    input  logic [31:0] ld_addr,
    input  logic        ld_byte,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic        st_byte,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_byte,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        ld_done,
    output logic [31:0] ld_done_pc,
    output logic [31:0] ld_data
);
    localparam int PTR_W = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;
    localparam int SV_W  = $clog2(STARVE_MAX + 1);
    localparam logic [PTR_W:0]   FULL_CNT   = (PTR_W + 1)'(SB_DEPTH);
    localparam logic [PTR_W:0]   ZERO_CNT   = (PTR_W + 1)'(0);
    localparam logic [SV_W-1:0]  STARVE_LIM = SV_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_t;

    state_t            state_r;
    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic [PTR_W:0]    count_r;
    logic [SV_W-1:0]   starve_r;
    logic [31:0]       pend_pc_r;
    logic [31:0]       sb_addr_r [SB_DEPTH];
    logic [31:0]       sb_data_r [SB_DEPTH];
    logic              sb_byte_r [SB_DEPTH];

    logic [PTR_W-1:0]  idx_s;
    logic [PTR_W-1:0]  fwd_idx_s;
    logic              match_s;
    logic              fwd_ok_s;
    logic              store_prio_s;
    logic              ld_fire_s;
    logic              st_push_s;
    logic              sb_pop_s;
    logic              store_issue_s;

    function automatic logic [31:0] fmt_load(input logic [31:0] d, input logic b);
        if (b) begin
            return {24'h000000, d[7:0]};
        end else begin
            return d;
        end
    endfunction

    // Youngest same-word buffered store decides forward vs. hold; scan runs oldest to youngest.
    always_comb begin
        match_s   = 1'b0;
        fwd_idx_s = head_r;
        idx_s     = head_r;
        for (int i = 0; i < SB_DEPTH; i++) begin
            idx_s = head_r + PTR_W'(i);
            if (((PTR_W + 1)'(i) < count_r) && (sb_addr_r[idx_s][31:2] == ld_addr[31:2])) begin
                match_s   = 1'b1;
                fwd_idx_s = idx_s;
            end else begin
                match_s   = match_s;
                fwd_idx_s = fwd_idx_s;
            end
        end
        fwd_ok_s      = match_s && (sb_addr_r[fwd_idx_s] == ld_addr) && (sb_byte_r[fwd_idx_s] == ld_byte);
        store_prio_s  = (count_r == FULL_CNT) || ((starve_r == STARVE_LIM) && (count_r != ZERO_CNT));
        ld_ready      = (state_r == IDLE) && !(match_s && !fwd_ok_s) && !store_prio_s;
        st_ready      = (count_r < FULL_CNT);
        ld_fire_s     = ld_valid && ld_ready;
        st_push_s     = st_valid && st_ready;
        sb_pop_s      = (state_r == WR_WAIT) && mem_ack;
        store_issue_s = (state_r == IDLE) && !ld_fire_s && (count_r != ZERO_CNT);
    end

    // Store buffer payload; contents are qualified by count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (st_push_s) begin
            sb_addr_r[tail_r] <= st_addr;
            sb_data_r[tail_r] <= st_data;
            sb_byte_r[tail_r] <= st_byte;
        end
    end

    // Control FSM, FIFO pointers, starvation counter and all registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r    <= IDLE;
            head_r     <= PTR_W'(0);
            tail_r     <= PTR_W'(0);
            count_r    <= ZERO_CNT;
            starve_r   <= SV_W'(0);
            pend_pc_r  <= 32'h0000_0000;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'h0000_0000;
            mem_wdata  <= 32'h0000_0000;
            mem_byte   <= 1'b0;
            ld_done    <= 1'b0;
            ld_done_pc <= 32'h0000_0000;
            ld_data    <= 32'h0000_0000;
        end else begin
            ld_done <= 1'b0;
            if (st_push_s) begin
                tail_r <= tail_r + PTR_W'(1);
            end
            if (sb_pop_s) begin
                head_r <= head_r + PTR_W'(1);
            end
            case ({st_push_s, sb_pop_s})
                2'b10:   count_r <= count_r + (PTR_W + 1)'(1);
                2'b01:   count_r <= count_r - (PTR_W + 1)'(1);
                default: count_r <= count_r;
            endcase
            if (count_r == ZERO_CNT || store_issue_s) begin
                starve_r <= SV_W'(0);
            end else if (ld_fire_s && starve_r != STARVE_LIM) begin
                starve_r <= starve_r + SV_W'(1);
            end
            case (state_r)
                IDLE: begin
                    if (ld_fire_s && fwd_ok_s) begin
                        ld_done    <= 1'b1;
                        ld_done_pc <= ld_pc;
                        ld_data    <= fmt_load(sb_data_r[fwd_idx_s], ld_byte);
                    end else if (ld_fire_s) begin
                        state_r   <= RD_WAIT;
                        pend_pc_r <= ld_pc;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= ld_addr;
                        mem_wdata <= 32'h0000_0000;
                        mem_byte  <= ld_byte;
                    end else if (store_issue_s) begin
                        state_r   <= WR_WAIT;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= sb_addr_r[head_r];
                        mem_wdata <= sb_data_r[head_r];
                        mem_byte  <= sb_byte_r[head_r];
                    end
                end
                RD_WAIT: begin
                    if (mem_ack) begin
                        state_r    <= IDLE;
                        mem_req    <= 1'b0;
                        ld_done    <= 1'b1;
                        ld_done_pc <= pend_pc_r;
                        ld_data    <= fmt_load(mem_rdata, mem_byte);
                    end
                end
                WR_WAIT: begin
                    if (mem_ack) begin
                        state_r <= IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: expected memory requests and load
// completions are queued as stimulus is driven and popped as the DUT produces them.
module tb_dmem_port_arbiter;
    logic        clk, rstn;
    logic        ld_valid, ld_ready, ld_byte;
    logic [31:0] ld_pc, ld_addr;
    logic        st_valid, st_ready, st_byte;
    logic [31:0] st_addr, st_data;
    logic        mem_req, mem_we, mem_byte, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        ld_done;
    logic [31:0] ld_done_pc, ld_data;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic        sz_byte;
    } mreq_t;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ldexp_t;

    mreq_t       mq[$];
    ldexp_t      lq[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          lat = 1;
    bit          busy = 1'b0;
    int          wcnt = 0;
    logic [31:0] rd_val = 32'h0;
    int          ld_grants = 0;
    int          grants_at_wr = 0;
    int          base;

    dmem_port_arbiter #(.SB_DEPTH(4), .STARVE_MAX(4)) dut (
        .clk(clk), .rstn(rstn),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_pc(ld_pc), .ld_addr(ld_addr), .ld_byte(ld_byte),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data), .st_byte(st_byte),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_byte(mem_byte),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ld_done(ld_done), .ld_done_pc(ld_done_pc), .ld_data(ld_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic exp_rd(input logic [31:0] a, input logic [31:0] rdata, input logic b);
        mq.push_back('{1'b0, a, rdata, b});
    endtask

    task automatic exp_wr(input logic [31:0] a, input logic [31:0] d, input logic b);
        mq.push_back('{1'b1, a, d, b});
    endtask

    task automatic exp_ld(input logic [31:0] pc, input logic [31:0] d);
        lq.push_back('{pc, d});
    endtask

    task automatic do_load(input logic [31:0] pc, input logic [31:0] a, input logic b, input int bound);
        bit ok = 1'b0;
        ld_valid = 1'b1; ld_pc = pc; ld_addr = a; ld_byte = b;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            if (ld_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        ld_valid = 1'b0;
        if (!ok) chk("ld_accept_timeout", {31'd0, ld_ready}, 32'd1);
        else ld_grants++;
    endtask

    task automatic push_store(input logic [31:0] a, input logic [31:0] d, input logic b);
        bit ok = 1'b0;
        st_valid = 1'b1; st_addr = a; st_data = d; st_byte = b;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (st_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        st_valid = 1'b0;
        if (!ok) chk("st_accept_timeout", {31'd0, st_ready}, 32'd1);
    endtask

    task automatic drain(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (mq.size() == 0 && lq.size() == 0 && mem_req !== 1'b1 && !busy) break;
            @(posedge clk); #1;
        end
        chk("drain_mem_q", 32'(mq.size()), 32'd0);
        chk("drain_ld_q", 32'(lq.size()), 32'd0);
    endtask

    // Memory responder: checks each new request against the queue, acks after lat cycles.
    initial begin : resp
        mreq_t e;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (busy) begin
                if (wcnt <= 1) begin
                    mem_ack = 1'b1; mem_rdata = rd_val; busy = 1'b0;
                end else begin
                    wcnt--;
                end
            end else if (mem_req === 1'b1) begin
                if (mq.size() == 0) begin
                    chk("mem_unexp_req", {31'd0, mem_req}, 32'd0);
                    rd_val = 32'h0;
                end else begin
                    e = mq.pop_front();
                    chk("mem_we", {31'd0, mem_we}, {31'd0, e.we});
                    chk("mem_addr", mem_addr, e.addr);
                    chk("mem_byte", {31'd0, mem_byte}, {31'd0, e.sz_byte});
                    if (e.we) begin
                        chk("mem_wdata", mem_wdata, e.data);
                        grants_at_wr = ld_grants;
                    end
                    rd_val = e.data;
                end
                busy = 1'b1; wcnt = lat;
            end
        end
    end

    // Load completion monitor.
    initial begin : ldmon
        ldexp_t e;
        forever begin
            @(negedge clk);
            if (ld_done === 1'b1) begin
                if (lq.size() == 0) begin
                    chk("ld_unexp_done", {31'd0, ld_done}, 32'd0);
                end else begin
                    e = lq.pop_front();
                    chk("ld_done_pc", ld_done_pc, e.pc);
                    chk("ld_data", ld_data, e.data);
                end
            end
        end
    end

    initial begin
        #400000;
        n_fail++;
        $display("FAIL global_timeout: time %0t exceeded limit", $time);
        $fatal(1, "timeout");
    end

    initial begin
        rstn = 1'b0; ld_valid = 1'b0; ld_pc = 32'h0; ld_addr = 32'h0; ld_byte = 1'b0;
        st_valid = 1'b0; st_addr = 32'h0; st_data = 32'h0; st_byte = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_ld_done", {31'd0, ld_done}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_st_ready", {31'd0, st_ready}, 32'd1);
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("idle_ld_ready", {31'd0, ld_ready}, 32'd1);

        // Load misses: word, then byte
        lat = 3;
        exp_rd(32'h0000_0100, 32'hDEAD_BEEF, 1'b0);
        exp_ld(32'h0000_1000, 32'hDEAD_BEEF);
        do_load(32'h0000_1000, 32'h0000_0100, 1'b0, 20);
        drain(50);
        lat = 1;
        exp_rd(32'h0000_0105, 32'h1122_3344, 1'b1);
        exp_ld(32'h0000_1004, 32'h0000_0044);
        do_load(32'h0000_1004, 32'h0000_0105, 1'b1, 20);
        drain(50);

        // Forwarding: stores buffered while an earlier load occupies the port
        lat = 4;
        exp_rd(32'h0000_0180, 32'h0BAD_F00D, 1'b0);
        exp_ld(32'h0000_2000, 32'h0BAD_F00D);
        do_load(32'h0000_2000, 32'h0000_0180, 1'b0, 20);
        exp_wr(32'h0000_0200, 32'h1234_5678, 1'b0);
        exp_wr(32'h0000_0204, 32'hCAFE_BABE, 1'b1);
        push_store(32'h0000_0200, 32'h1234_5678, 1'b0);
        push_store(32'h0000_0204, 32'hCAFE_BABE, 1'b1);
        lat = 1;
        exp_ld(32'h0000_2001, 32'h1234_5678);
        do_load(32'h0000_2001, 32'h0000_0200, 1'b0, 30);
        @(negedge clk);
        chk("fwd_done_next", {31'd0, ld_done}, 32'd1);
        chk("fwd_no_mem_req", {31'd0, mem_req}, 32'd0);
        @(posedge clk); #1;
        exp_ld(32'h0000_2002, 32'h0000_00BE);
        do_load(32'h0000_2002, 32'h0000_0204, 1'b1, 30);
        drain(50);

        // Hold: word load over a buffered byte store waits for the drain
        lat = 2;
        exp_wr(32'h0000_0300, 32'h0000_00A5, 1'b1);
        push_store(32'h0000_0300, 32'h0000_00A5, 1'b1);
        ld_valid = 1'b1; ld_pc = 32'h0000_3000; ld_addr = 32'h0000_0300; ld_byte = 1'b0;
        @(negedge clk);
        chk("hold_ld_ready", {31'd0, ld_ready}, 32'd0);
        exp_rd(32'h0000_0300, 32'h7766_5544, 1'b0);
        exp_ld(32'h0000_3000, 32'h7766_5544);
        do_load(32'h0000_3000, 32'h0000_0300, 1'b0, 50);
        drain(50);

        // Full buffer: 4 stores, conflicting load held until all drain in order
        lat = 12;
        exp_rd(32'h0000_0600, 32'hA5A5_0000, 1'b0);
        exp_ld(32'h0000_4000, 32'hA5A5_0000);
        do_load(32'h0000_4000, 32'h0000_0600, 1'b0, 20);
        for (int i = 0; i < 4; i++) begin
            exp_wr(32'h0000_0700 + 32'(4 * i), 32'h0F00_0000 + 32'(i), (i == 3) ? 1'b1 : 1'b0);
            push_store(32'h0000_0700 + 32'(4 * i), 32'h0F00_0000 + 32'(i), (i == 3) ? 1'b1 : 1'b0);
        end
        @(negedge clk);
        chk("full_st_ready", {31'd0, st_ready}, 32'd0);
        @(posedge clk); #1;
        lat = 2;
        exp_rd(32'h0000_070C, 32'h4444_5555, 1'b0);
        exp_ld(32'h0000_4001, 32'h4444_5555);
        do_load(32'h0000_4001, 32'h0000_070C, 1'b0, 150);
        drain(80);

        // Starvation: one buffered store, continuous loads
        lat = 4;
        exp_rd(32'h0000_0880, 32'h5000_0000, 1'b0);
        exp_ld(32'h0000_5000, 32'h5000_0000);
        do_load(32'h0000_5000, 32'h0000_0880, 1'b0, 20);
        push_store(32'h0000_0800, 32'h0000_5555, 1'b0);
        lat = 1;
        base = ld_grants;
        for (int i = 1; i <= 4; i++) begin
            exp_rd(32'h0000_0900 + 32'(4 * i), 32'h5000_0000 + 32'(i), 1'b0);
            exp_ld(32'h0000_5000 + 32'(i), 32'h5000_0000 + 32'(i));
            do_load(32'h0000_5000 + 32'(i), 32'h0000_0900 + 32'(4 * i), 1'b0, 30);
        end
        exp_wr(32'h0000_0800, 32'h0000_5555, 1'b0);
        exp_rd(32'h0000_0920, 32'h5000_0005, 1'b0);
        exp_ld(32'h0000_5005, 32'h5000_0005);
        do_load(32'h0000_5005, 32'h0000_0920, 1'b0, 30);
        drain(50);
        chk("starve_grants", 32'(grants_at_wr - base), 32'd4);

        // Reset during RD_WAIT followed by a late ack
        lat = 6;
        exp_rd(32'h0000_0500, 32'h9999_9999, 1'b0);
        do_load(32'h0000_6000, 32'h0000_0500, 1'b0, 20);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        chk("mid_rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("mid_rst_ld_data", ld_data, 32'd0);
        chk("mid_rst_ld_pc", ld_done_pc, 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_ld_ready", {31'd0, ld_ready}, 32'd1);
        chk("post_rst_st_ready", {31'd0, st_ready}, 32'd1);
        chk("post_rst_mem_req", {31'd0, mem_req}, 32'd0);
        lat = 1;
        exp_rd(32'h0000_0504, 32'h1357_9BDF, 1'b0);
        exp_ld(32'h0000_6001, 32'h1357_9BDF);
        do_load(32'h0000_6001, 32'h0000_0504, 1'b0, 20);
        drain(50);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
